// File: rtl/alu_serial_rx.sv
// Serial front-end of the ALU: reassembles 11-bit packets from sin into B/A/CTL frames,
// checks count/CRC/opcode and offers the decoded frame over valid/ready. Optional: ALU_RX_TIMEOUT_EN.
module alu_serial_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] a_data,
   output logic [31:0] b_data,
   output logic [2:0]  op,
   output logic [2:0]  err_flags,
   output logic        overrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TYPE,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        type_q, type_d;
   logic [7:0]  byte_q, byte_d;
   logic [63:0] shift_q, shift_d;
   logic [3:0]  pkt_cnt_q, pkt_cnt_d;
   logic        frame_err_q, frame_err_d;
   logic        fend_q, fend_d;
   logic [6:0]  ctl_q, ctl_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic [2:0]  err_q, err_d;
   logic        ovr_q, ovr_d;

   logic        pkt_done;
   logic        pkt_ferr;
   logic        err_data, err_crc, err_op;
   logic        op_legal;
   logic [3:0]  crc_calc;

`ifdef ALU_RX_TIMEOUT_EN
   localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
   logic [ToW-1:0] to_cnt_q, to_cnt_d;
`endif

   // Serial CRC x^4+x+1, init 0, MSB of d first.
   function automatic logic [3:0] crc4_f(input logic [67:0] d);
      logic [3:0] c;
      logic       fb;
      c = '0;
      for (int unsigned i = 0; i < 68; i++) begin
         fb = c[3] ^ d[67 - i];
         c  = {c[2], c[1], c[0] ^ fb, fb};
      end
      return c;
   endfunction

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      type_d    = type_q;
      byte_d    = byte_q;
      pkt_done  = 1'b0;
      pkt_ferr  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!sin) state_d = S_TYPE;
         end
         S_TYPE: begin
            type_d    = sin;
            bit_cnt_d = '0;
            state_d   = S_DATA;
         end
         S_DATA: begin
            byte_d    = {byte_q[6:0], sin};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = S_STOP;
         end
         S_STOP: begin
            if (sin) begin
               pkt_done = 1'b1;
               state_d  = S_IDLE;
            end else begin
               pkt_ferr = 1'b1;
               state_d  = S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            if (sin) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Frame checks are evaluated one cycle after the CTL stop bit, from registered frame state.
   always_comb begin
      crc_calc = crc4_f({shift_q, 1'b1, ctl_q[6:4]});
      unique case (ctl_q[6:4])
         3'b000, 3'b001, 3'b100, 3'b101: op_legal = 1'b1;
         default:                        op_legal = 1'b0;
      endcase
      err_data = (pkt_cnt_q != 4'd8) || frame_err_q;
      err_crc  = !err_data && (crc_calc != ctl_q[3:0]);
      err_op   = !err_data && !err_crc && !op_legal;
   end

   always_comb begin
      shift_d     = shift_q;
      pkt_cnt_d   = pkt_cnt_q;
      frame_err_d = frame_err_q;
      fend_d      = 1'b0;
      ctl_d       = ctl_q;
      out_valid_d = out_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      err_d       = err_q;
      ovr_d       = 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif

      if (pkt_done && !type_q) begin
         shift_d = {shift_q[55:0], byte_q};
         if (pkt_cnt_q != 4'd9) pkt_cnt_d = pkt_cnt_q + 4'd1;
      end
      if (pkt_done && type_q) begin
         fend_d = 1'b1;
         ctl_d  = byte_q[6:0];
      end
      if (pkt_ferr) frame_err_d = 1'b1;

`ifdef ALU_RX_TIMEOUT_EN
      if (state_q == S_IDLE && !sin) begin
         to_cnt_d = '0;
      end else if (state_q == S_IDLE && pkt_cnt_q != 4'd0) begin
         if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_d    = '0;
            pkt_cnt_d   = '0;
            frame_err_d = 1'b0;
            shift_d     = '0;
         end else begin
            to_cnt_d = to_cnt_q + ToW'(1);
         end
      end
`endif

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (fend_q) begin
         pkt_cnt_d   = '0;
         frame_err_d = 1'b0;
         shift_d     = '0;
`ifdef ALU_RX_TIMEOUT_EN
         to_cnt_d    = '0;
`endif
         if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            b_d         = shift_q[63:32];
            a_d         = shift_q[31:0];
            op_d        = ctl_q[6:4];
            err_d       = {err_data, err_crc, err_op};
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         type_q      <= 1'b0;
         byte_q      <= '0;
         shift_q     <= '0;
         pkt_cnt_q   <= '0;
         frame_err_q <= 1'b0;
         fend_q      <= 1'b0;
         ctl_q       <= '0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         err_q       <= '0;
         ovr_q       <= 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         type_q      <= type_d;
         byte_q      <= byte_d;
         shift_q     <= shift_d;
         pkt_cnt_q   <= pkt_cnt_d;
         frame_err_q <= frame_err_d;
         fend_q      <= fend_d;
         ctl_q       <= ctl_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         err_q       <= err_d;
         ovr_q       <= ovr_d;
`ifdef ALU_RX_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign a_data    = a_q;
   assign b_data    = b_q;
   assign op        = op_q;
   assign err_flags = err_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Self-checking bench for alu_serial_rx: directed test-plan frames plus randomized frames
// checked against a frame-level reference model (polynomial-division CRC, packet list per frame).
module tb_alu_serial_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sin = 1'b1;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] a_data, b_data;
   logic [2:0]  op, err_flags;
   logic        overrun;

   alu_serial_rx #(.TIMEOUT_CYCLES(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sin       (sin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_data    (a_data),
      .b_data    (b_data),
      .op        (op),
      .err_flags (err_flags),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ovr_seen = 0;

   // reference model state
   logic [7:0]  m_bytes[$];
   bit          m_ferr = 1'b0;
   bit          m_valid = 1'b0;
   logic [31:0] m_a = '0, m_b = '0;
   logic [2:0]  m_op = '0, m_err = '0;
   int          m_ovr = 0;

   always @(negedge clk) if (rst_n && overrun === 1'b1) ovr_seen++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_crc(input logic [67:0] d);
      logic [71:0] r;
      r = {d, 4'b0000};
      for (int i = 71; i >= 4; i--)
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      return r[3:0];
   endfunction

   function automatic logic [7:0] mk_ctl(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o);
      return {1'b0, o, ref_crc({b, a, 1'b1, o})};
   endfunction

   task automatic frame_end(input logic [7:0] ctl);
      int n;
      logic [31:0] b, a;
      logic [2:0]  e;
      n = m_bytes.size();
      b = '0;
      a = '0;
      if (n == 8) begin
         b = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
         a = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
      end
      if (n != 8 || m_ferr)                                e = 3'b100;
      else if (ref_crc({b, a, 1'b1, ctl[6:4]}) != ctl[3:0]) e = 3'b010;
      else if (ctl[5] == 1'b0)                              e = 3'b000;
      else                                                  e = 3'b001;
      if (m_valid) m_ovr++;
      else begin
         m_valid = 1'b1;
         m_a = a;
         m_b = b;
         m_op = ctl[6:4];
         m_err = e;
      end
      m_bytes.delete();
      m_ferr = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk) sin = 1'b1;
   endtask

   task automatic send_pkt(input bit typ, input logic [7:0] pay, input bit stop_ok);
      bit was_valid;
      @(negedge clk) sin = 1'b0;
      @(negedge clk) sin = typ;
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk) sin = pay[i];
      end
      @(negedge clk) sin = stop_ok;
      if (!stop_ok) begin
         @(negedge clk) sin = 1'b1;
         m_ferr = 1'b1;
      end else if (!typ) begin
         m_bytes.push_back(pay);
      end else begin
         was_valid = m_valid;
         @(negedge clk) sin = 1'b1;
         chk("latency_hold", out_valid, was_valid);
         @(negedge clk);
         frame_end(pay);
         chk("latency_valid", out_valid, 1);
      end
   endtask

   task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [7:0] ctl,
                             input int ndata, input int bad_idx, input int maxgap);
      logic [63:0] ba;
      logic [7:0]  by;
      ba = {b, a};
      for (int i = 0; i < ndata; i++) begin
         if (i < 8) by = ba[63 - 8*i -: 8];
         else       by = 8'($urandom);
         send_pkt(1'b0, by, i != bad_idx);
         gap($urandom_range(0, maxgap));
      end
      send_pkt(1'b1, ctl, 1'b1);
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_valid"}, out_valid, m_valid);
      if (m_valid) begin
         chk({tag, "_err"}, err_flags, m_err);
         chk({tag, "_op"}, op, m_op);
         if (m_err != 3'b100) begin
            chk({tag, "_a"}, a_data, m_a);
            chk({tag, "_b"}, b_data, m_b);
         end
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      m_valid = 1'b0;
      chk("pop_valid_low", out_valid, 0);
   endtask

   initial begin
      logic [31:0] rb, ra;
      logic [2:0]  ro;
      logic [7:0]  rc;
      int          nd, bad;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_a", a_data, 0);
      chk("rst_b", b_data, 0);
      chk("rst_op", op, 0);
      chk("rst_err", err_flags, 0);
      chk("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      gap(2);

      // add, good CRC
      send_frame(32'h2, 32'h1, 8'h4C, 8, -1, 0);
      check_out("tp_add");
      chk("tp_add_err_const", err_flags, 3'b000);
      chk("tp_add_a_const", a_data, 32'h1);
      chk("tp_add_b_const", b_data, 32'h2);
      chk("tp_add_op_const", op, 3'b100);
      pop();

      // bad CRC
      send_frame(32'h2, 32'h1, 8'h4D, 8, -1, 1);
      check_out("tp_crc");
      chk("tp_crc_const", err_flags, 3'b010);
      pop();

      // short frame: two B bytes, two A bytes
      send_pkt(1'b0, 8'h00, 1'b1);
      send_pkt(1'b0, 8'h02, 1'b1);
      send_pkt(1'b0, 8'h00, 1'b1);
      send_pkt(1'b0, 8'h01, 1'b1);
      send_pkt(1'b1, 8'h4C, 1'b1);
      check_out("tp_short");
      chk("tp_short_const", err_flags, 3'b100);
      pop();

      // illegal opcode
      send_frame(32'h2, 32'h1, 8'h26, 8, -1, 0);
      check_out("tp_op");
      chk("tp_op_const", err_flags, 3'b001);
      pop();

      // framing error in third DATA packet
      send_frame(32'h2, 32'h1, 8'h4C, 8, 2, 0);
      check_out("tp_ferr");
      chk("tp_ferr_const", err_flags, 3'b100);
      pop();

      // reset after five packets of the next frame
      for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
      @(negedge clk) rst_n = 1'b0;
      m_bytes.delete();
      m_ferr = 1'b0;
      m_valid = 1'b0;
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_a", a_data, 0);
      rst_n = 1'b1;
      gap(20);
      chk("midrst_no_valid", out_valid, 0);
      send_frame(32'h2, 32'h1, 8'h4C, 8, -1, 0);
      check_out("tp_after_rst");
      chk("tp_after_rst_const", err_flags, 3'b000);
      pop();

      // overrun: two frames back to back, output not accepted
      rb = $urandom; ra = $urandom;
      send_frame(rb, ra, mk_ctl(rb, ra, 3'b101), 8, -1, 0);
      send_frame(32'h2, 32'h1, 8'h4C, 8, -1, 0);
      gap(3);
      chk("ovr_count", ovr_seen, m_ovr);
      chk("ovr_count_const", ovr_seen, 1);
      check_out("ovr_held");
      chk("ovr_held_a", a_data, ra);
      pop();

      // partial frame followed by a long idle period
      for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
      gap(70);
`ifdef ALU_RX_TIMEOUT_EN
      m_bytes.delete();
      m_ferr = 1'b0;
`endif
      chk("idle_no_valid", out_valid, 0);
      send_frame(32'h2, 32'h1, 8'h4C, 8, -1, 0);
      check_out("after_idle");
      pop();
`ifndef ALU_RX_TIMEOUT_EN
      send_frame(32'h2, 32'h1, 8'h4C, 8, -1, 0);
      check_out("after_idle2");
      pop();
`endif

      // randomized frames
      for (int k = 0; k < 24; k++) begin
         rb = $urandom;
         ra = $urandom;
         ro = 3'($urandom);
         rc = mk_ctl(rb, ra, ro);
         if ($urandom_range(0, 3) == 0) rc[3:0] = rc[3:0] ^ 4'($urandom_range(1, 15));
         nd = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : 8;
         bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : -1;
         send_frame(rb, ra, rc, nd, bad, 2);
         check_out("rand");
         pop();
      end
      chk("final_ovr_count", ovr_seen, m_ovr);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_serial_rx.md
# alu_serial_rx

Serial front-end of the ALU: samples the single-wire `sin` line, reassembles 11-bit packets, collects the B and A operands plus the control packet of one frame, checks packet count, CRC and opcode, and presents a decoded operation with error flags to the ALU execute stage over a valid/ready handshake. It sits between the testbench driver (or pad) on `sin` and the arithmetic core.

## Interface
- `TIMEOUT_CYCLES`, default 64: idle cycles after which a partial frame is discarded (used only with `ALU_RX_TIMEOUT_EN`).
- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sin` input 1: serial line; idle high.
- `out_valid` output 1: decoded frame available.
- `out_ready` input 1: consumer accepts frame.
- `a_data` output 32: operand A.
- `b_data` output 32: operand B.
- `op` output 3: opcode from the control packet.
- `err_flags` output 3: {err_data, err_crc, err_op}.
- `overrun` output 1: one-cycle pulse, frame dropped because the output was still occupied.

## Operation
- Packet, one bit per posedge: start (0), type (0 = DATA, 1 = CTL), 8 payload bits MSB first, stop (1).
- Bit FSM: IDLE → TYPE → DATA (3-bit counter, 8 bits) → STOP → IDLE. IDLE leaves on `sin`=0. Stop bit sampled 0 → packet discarded, current frame marked data-error, FSM goes to WAIT_HIGH until `sin`=1, then IDLE.
- Frame: DATA packets shifted into a 64-bit register; first four are B (MSB byte first), next four A. 4-bit packet counter saturates at 9.
- CTL packet payload = {1'b0, op[2:0], crc[3:0]}; it ends the frame:
  - err_data if packet count ≠ 8 or any framing error occurred in the frame.
  - else err_crc if received crc ≠ CRC over d[67:0] = {B, A, 1'b1, op}, polynomial x^4+x+1, init 0, d[67] first (serial LFSR: fb = c[3]^d; c ← {c[2], c[1], c[0]^fb, fb}).
  - else err_op if op not in {000 and, 001 or, 100 add, 101 sub}.
  - Only the highest-priority flag is set (data > crc > op).
- Frame end loads outputs and sets `out_valid`; packet counter and frame error state clear.
- On error, `a_data`/`b_data` carry whatever was collected (zero-filled); consumers ignore them.
- Output register is one deep. If a frame ends while `out_valid`=1 and `out_ready`=0, the new frame is dropped, `overrun` pulses, and held outputs are unchanged.

## Timing
- Reset: FSM IDLE, counters 0, `out_valid`=0, `a_data`=`b_data`=0, `op`=0, `err_flags`=0, `overrun`=0. Reset mid-frame discards the partial frame.
- Latency: `out_valid` rises at the first posedge after the edge that sampled the CTL stop bit.
- Handshake: transfer on posedge with `out_valid`&`out_ready`; `out_valid` falls next cycle unless a frame ends the same cycle, in which case the new frame loads and `out_valid` stays high (no overrun).
- Outputs are stable while `out_valid`=1 and not accepted.
- Back-to-back packets (start bit right after stop) accepted with no gap.

## Configuration
- `ALU_RX_TIMEOUT_EN` defined: a counter runs while a frame is partial (1–8+ packets) and FSM is IDLE; reaching `TIMEOUT_CYCLES` discards the frame silently (no `out_valid`), counter clears on any start bit.
- Undefined: no timeout; a partial frame waits indefinitely for its CTL packet.

## Test plan
- B=0x00000002, A=0x00000001, CTL 0x4C (add, crc 1100) → `out_valid`, a=1, b=2, op=100, err=000.
- Same operands, CTL 0x4D → err=010.
- Two B packets, two A packets, then CTL 0x4C → err=100 (priority over CRC).
- B=2, A=1, CTL 0x26 (op 010, crc 0110) → err=001.
- Stop bit 0 in third DATA packet, rest of frame valid → err=100; then `rst_n` low after five packets of next frame → no `out_valid`; following clean frame decodes with err=000.
- `out_ready`=0, two valid frames back to back → first held, `overrun` one-cycle pulse; with `ALU_RX_TIMEOUT_EN`, three packets then 64 idle cycles → no output, next clean frame err=000.
